// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: ROWS x COLS grid selector for the VGA path.
// Debounces the active-low buttons and turns each press into a single cursor
// move or mark toggle. It also colours the current pixel: grid lines, cursor
// cell, marked cells or background.
// Ports:
//   i_clk, i_rst          pixel clock, synchronous active-high reset
//   i_xpos, i_ypos        current pixel column / row (unsigned 16-bit)
//   i_btn_up/down/left/right/sel  active-low push-buttons, asynchronous to i_clk
//   o_red, o_green, o_blue        registered 4-bit pixel colour (1-cycle latency)
//   o_cursor_row, o_cursor_col    current cursor cell
//   o_mark_map                    bit r*COLS+c = mark of cell (r,c)
//   o_move_pulse                  1-cycle strobe, high with the new cursor position
module grid_cursor_ctrl #(
    parameter int unsigned H_RES        = 640,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned COLS         = 3,
    parameter int unsigned ROWS         = 3,
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned WRAP         = 0,
    parameter logic [11:0] C_LINE       = 12'h000,
    parameter logic [11:0] C_CURSOR     = 12'h222,
    parameter logic [11:0] C_MARK       = 12'h0F0,
    parameter logic [11:0] C_BG         = 12'h111,
    localparam int unsigned RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW          = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned NCELL       = ROWS * COLS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [15:0]      i_xpos,
    input  logic [15:0]      i_ypos,
    input  logic             i_btn_up,
    input  logic             i_btn_down,
    input  logic             i_btn_left,
    input  logic             i_btn_right,
    input  logic             i_btn_sel,
    output logic [3:0]       o_red,
    output logic [3:0]       o_green,
    output logic [3:0]       o_blue,
    output logic [RW-1:0]    o_cursor_row,
    output logic [CW-1:0]    o_cursor_col,
    output logic [NCELL-1:0] o_mark_map,
    output logic             o_move_pulse
);

    localparam int unsigned NB     = 5;
    localparam int unsigned B_UP   = 0;
    localparam int unsigned B_DOWN = 1;
    localparam int unsigned B_LEFT = 2;
    localparam int unsigned B_RGT  = 3;
    localparam int unsigned B_SEL  = 4;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam int unsigned CELL_W = H_RES / COLS;
    localparam int unsigned CELL_H = V_RES / ROWS;

    logic [NB-1:0]    w_btn_n;
    logic [NB-1:0]    r_sync1;
    logic [NB-1:0]    r_sync2;
    logic [NB-1:0]    r_deb;      // debounced level, 1 = released
    logic [NB-1:0]    r_press;    // 1-cycle press strobes
    logic [CNT_W-1:0] r_cnt [NB];

    logic [RW-1:0]    r_row, w_row_nxt;
    logic [CW-1:0]    r_col, w_col_nxt;
    logic [NCELL-1:0] r_mark, w_mark_nxt;
    logic             r_move, w_moved;

    logic [CW-1:0]    w_px_col;
    logic [RW-1:0]    w_px_row;
    logic             w_vline, w_hline, w_in_view, w_cur_hit, w_mark_hit;
    logic [11:0]      w_rgb, r_rgb;

    assign w_btn_n = {i_btn_sel, i_btn_right, i_btn_left, i_btn_down, i_btn_up};

    // Synchronise, debounce and edge-detect every button.
    // The counter only advances while the synced level disagrees with the
    // debounced level, so any bounce back restarts the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_deb   <= '1;
            r_press <= '0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn_n;
            r_sync2 <= r_sync1;
            r_press <= '0;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_cnt[i]   <= '0;
                    r_deb[i]   <= r_sync2[i];
                    r_press[i] <= ~r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Next cursor position: one move per cycle, Up > Down > Left > Right.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        w_moved   = 1'b0;
        if (r_press[B_UP]) begin
            if (r_row != '0) begin
                w_row_nxt = r_row - RW'(1);
                w_moved   = 1'b1;
            end else if (WRAP != 0) begin
                w_row_nxt = RW'(ROWS - 1);
                w_moved   = 1'b1;
            end
        end else if (r_press[B_DOWN]) begin
            if (r_row != RW'(ROWS - 1)) begin
                w_row_nxt = r_row + RW'(1);
                w_moved   = 1'b1;
            end else if (WRAP != 0) begin
                w_row_nxt = '0;
                w_moved   = 1'b1;
            end
        end else if (r_press[B_LEFT]) begin
            if (r_col != '0) begin
                w_col_nxt = r_col - CW'(1);
                w_moved   = 1'b1;
            end else if (WRAP != 0) begin
                w_col_nxt = CW'(COLS - 1);
                w_moved   = 1'b1;
            end
        end else if (r_press[B_RGT]) begin
            if (r_col != CW'(COLS - 1)) begin
                w_col_nxt = r_col + CW'(1);
                w_moved   = 1'b1;
            end else if (WRAP != 0) begin
                w_col_nxt = '0;
                w_moved   = 1'b1;
            end
        end
    end

    // Select toggles the cell the cursor occupies before this cycle's move.
    always_comb begin
        w_mark_nxt = r_mark;
        if (r_press[B_SEL]) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (RW'(r) == r_row && CW'(c) == r_col)
                        w_mark_nxt[r*COLS+c] = ~r_mark[r*COLS+c];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row  <= RW'(ROWS / 2);
            r_col  <= CW'(COLS / 2);
            r_mark <= '0;
            r_move <= 1'b0;
        end else begin
            r_row  <= w_row_nxt;
            r_col  <= w_col_nxt;
            r_mark <= w_mark_nxt;
            r_move <= w_moved;
        end
    end

    // Pixel cell lookup against constant boundaries; remainder pixels fall in the last cell.
    always_comb begin
        w_px_col = '0;
        w_vline  = 1'b0;
        for (int k = 1; k < COLS; k++) begin
            if (i_xpos >= 16'(k * CELL_W)) w_px_col = CW'(k);
            if (i_xpos == 16'(k * CELL_W)) w_vline  = 1'b1;
        end
        w_px_row = '0;
        w_hline  = 1'b0;
        for (int k = 1; k < ROWS; k++) begin
            if (i_ypos >= 16'(k * CELL_H)) w_px_row = RW'(k);
            if (i_ypos == 16'(k * CELL_H)) w_hline  = 1'b1;
        end
    end

    always_comb begin
        w_mark_hit = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (RW'(r) == w_px_row && CW'(c) == w_px_col)
                    w_mark_hit = r_mark[r*COLS+c];
            end
        end
    end

    assign w_in_view = (i_xpos < 16'(H_RES)) && (i_ypos < 16'(V_RES));
    assign w_cur_hit = (w_px_row == r_row) && (w_px_col == r_col);

    // Colour priority: off-screen, grid line, cursor, mark, background.
    always_comb begin
        w_rgb = C_BG;
        if (!w_in_view)            w_rgb = 12'h000;
        else if (w_vline || w_hline) w_rgb = C_LINE;
        else if (w_cur_hit)        w_rgb = C_CURSOR;
        else if (w_mark_hit)       w_rgb = C_MARK;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_rgb <= '0;
        else       r_rgb <= w_rgb;
    end

    assign o_red        = r_rgb[11:8];
    assign o_green      = r_rgb[7:4];
    assign o_blue       = r_rgb[3:0];
    assign o_cursor_row = r_row;
    assign o_cursor_col = r_col;
    assign o_mark_map   = r_mark;
    assign o_move_pulse = r_move;

endmodule

// File: tb/tb_grid_cursor_ctrl.sv
// tb_grid_cursor_ctrl: scoreboard bench for grid_cursor_ctrl.
// Instance a: 3x3 hold, b: 3x3 wrap, c: 4x2 hold; all with DEBOUNCE_CYC=4.
module tb_grid_cursor_ctrl;

    typedef struct packed { logic [1:0] row; logic [1:0] col; } mv_t;
    typedef struct { int d; logic [11:0] rgb; } px_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] xpos, ypos;
    logic [4:0]  btn_a, btn_b, btn_c;   // {sel,right,left,down,up}, active-low

    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic [1:0] a_row, a_col, b_row, b_col, c_col;
    logic       c_row;
    logic [8:0] a_map, b_map;
    logic [7:0] c_map;
    logic       a_mv, b_mv, c_mv;

    mv_t q_mv_a[$];
    mv_t q_mv_b[$];
    px_t q_pix[$];
    logic pix_vld, pix_vld_d;
    int   n_cmp = 0;
    int   n_err = 0;
    int   c_moves = 0;

    always #5 clk = ~clk;

    grid_cursor_ctrl #(.COLS(3), .ROWS(3), .DEBOUNCE_CYC(4), .WRAP(0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_xpos(xpos), .i_ypos(ypos),
        .i_btn_up(btn_a[0]), .i_btn_down(btn_a[1]), .i_btn_left(btn_a[2]),
        .i_btn_right(btn_a[3]), .i_btn_sel(btn_a[4]),
        .o_red(a_r), .o_green(a_g), .o_blue(a_b),
        .o_cursor_row(a_row), .o_cursor_col(a_col), .o_mark_map(a_map), .o_move_pulse(a_mv));

    grid_cursor_ctrl #(.COLS(3), .ROWS(3), .DEBOUNCE_CYC(4), .WRAP(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_xpos(xpos), .i_ypos(ypos),
        .i_btn_up(btn_b[0]), .i_btn_down(btn_b[1]), .i_btn_left(btn_b[2]),
        .i_btn_right(btn_b[3]), .i_btn_sel(btn_b[4]),
        .o_red(b_r), .o_green(b_g), .o_blue(b_b),
        .o_cursor_row(b_row), .o_cursor_col(b_col), .o_mark_map(b_map), .o_move_pulse(b_mv));

    grid_cursor_ctrl #(.COLS(4), .ROWS(2), .DEBOUNCE_CYC(4), .WRAP(0)) u_c (
        .i_clk(clk), .i_rst(rst), .i_xpos(xpos), .i_ypos(ypos),
        .i_btn_up(btn_c[0]), .i_btn_down(btn_c[1]), .i_btn_left(btn_c[2]),
        .i_btn_right(btn_c[3]), .i_btn_sel(btn_c[4]),
        .o_red(c_r), .o_green(c_g), .o_blue(c_b),
        .o_cursor_row(c_row), .o_cursor_col(c_col), .o_mark_map(c_map), .o_move_pulse(c_mv));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) pix_vld_d <= pix_vld;

    // Monitor: pixel results one cycle after request, moves on each move strobe.
    always @(negedge clk) begin
        if (pix_vld_d) begin
            if (q_pix.size() == 0) begin
                chk("pix_unexpected", 1, 0);
            end else begin
                px_t p;
                int  act;
                p = q_pix.pop_front();
                case (p.d)
                    0:       act = int'({a_r, a_g, a_b});
                    1:       act = int'({b_r, b_g, b_b});
                    default: act = int'({c_r, c_g, c_b});
                endcase
                chk($sformatf("pix_dut%0d", p.d), act, int'(p.rgb));
            end
        end
        if (a_mv) begin
            if (q_mv_a.size() == 0) chk("a_move_unexpected", 1, 0);
            else begin
                mv_t m;
                m = q_mv_a.pop_front();
                chk("a_move_rowcol", int'({a_row, a_col}), int'({m.row, m.col}));
            end
        end
        if (b_mv) begin
            if (q_mv_b.size() == 0) chk("b_move_unexpected", 1, 0);
            else begin
                mv_t m;
                m = q_mv_b.pop_front();
                chk("b_move_rowcol", int'({b_row, b_col}), int'({m.row, m.col}));
            end
        end
        if (c_mv) c_moves++;
    end

    task automatic pix(input int d, input int x, input int y, input logic [11:0] exp);
        px_t p;
        @(posedge clk); #1;
        xpos = 16'(x);
        ypos = 16'(y);
        p.d = d;
        p.rgb = exp;
        q_pix.push_back(p);
        pix_vld = 1'b1;
        @(posedge clk); #1;
        pix_vld = 1'b0;
    endtask

    task automatic press(input int d, input logic [4:0] mask, input int hold);
        @(posedge clk); #1;
        case (d)
            0:       btn_a = ~mask;
            1:       btn_b = ~mask;
            default: btn_c = ~mask;
        endcase
        repeat (hold) @(posedge clk);
        #1;
        btn_a = '1; btn_b = '1; btn_c = '1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic exp_a(input int r, input int c);
        mv_t m;
        m.row = 2'(r); m.col = 2'(c);
        q_mv_a.push_back(m);
    endtask

    task automatic exp_b(input int r, input int c);
        mv_t m;
        m.row = 2'(r); m.col = 2'(c);
        q_mv_b.push_back(m);
    endtask

    initial begin
        rst = 1'b1; btn_a = '1; btn_b = '1; btn_c = '1;
        xpos = 16'd300; ypos = 16'd200; pix_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_rgb_a", int'({a_r, a_g, a_b}), 'h000);
        chk("rst_row_a", int'(a_row), 1);
        chk("rst_col_a", int'(a_col), 1);
        chk("rst_map_a", int'(a_map), 0);
        chk("rst_row_c", int'(c_row), 1);
        chk("rst_col_c", int'(c_col), 2);
        rst = 1'b0;

        // Pixel colours after reset
        pix(0, 300, 200, 12'h222);
        pix(0, 100, 100, 12'h111);
        pix(0, 213, 50,  12'h000);
        pix(0, 700, 10,  12'h000);
        pix(0, 426, 479, 12'h000);
        pix(0, 639, 479, 12'h111);
        pix(0, 640, 0,   12'h000);
        pix(1, 100, 100, 12'h111);
        pix(2, 160, 100, 12'h000);
        pix(2, 320, 100, 12'h000);
        pix(2, 480, 100, 12'h000);
        pix(2, 100, 240, 12'h000);
        pix(2, 100, 100, 12'h111);
        pix(2, 400, 300, 12'h222);

        // Glitch shorter than debounce: no move
        @(posedge clk); #1;
        btn_a[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        btn_a[0] = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch_row", int'(a_row), 1);

        // Long hold: one move, DEBOUNCE_CYC+3 edges after first low sample
        exp_a(0, 1);
        btn_a[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("lat_before", int'(a_row), 1);
        @(posedge clk); #1;
        chk("lat_at", int'(a_row), 0);
        repeat (93) @(posedge clk);
        #1;
        btn_a[0] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("hold_row", int'(a_row), 0);

        // Up at row 0: hold on a, wrap on b
        press(0, 5'b00001, 10);
        chk("edge_hold_row", int'(a_row), 0);
        exp_b(0, 1);
        press(1, 5'b00001, 10);
        exp_b(2, 1);
        press(1, 5'b00001, 10);
        chk("wrap_row", int'(b_row), 2);

        // Simultaneous Up+Right from (1,1): Up wins
        exp_a(1, 1);
        press(0, 5'b00010, 10);
        exp_a(0, 1);
        press(0, 5'b01001, 10);
        chk("prio_row", int'(a_row), 0);
        chk("prio_col", int'(a_col), 1);

        // Marking
        exp_a(0, 2);
        press(0, 5'b01000, 10);
        press(0, 5'b10000, 10);
        chk("mark_set", int'(a_map), 'h004);
        exp_a(1, 2);
        press(0, 5'b00010, 10);
        pix(0, 500, 60,  12'h0F0);
        pix(0, 500, 200, 12'h222);
        pix(0, 300, 200, 12'h111);
        exp_a(0, 2);
        press(0, 5'b00001, 10);
        // Sel with Down: toggles the cell left behind
        exp_a(1, 2);
        press(0, 5'b10010, 10);
        chk("mark_clr", int'(a_map), 'h000);
        chk("sel_move_row", int'(a_row), 1);
        chk("sel_move_col", int'(a_col), 2);

        // Reset while Down is mid-debounce
        @(posedge clk); #1;
        btn_a[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        btn_a[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_row", int'(a_row), 1);
        chk("abort_col", int'(a_col), 1);
        chk("abort_map", int'(a_map), 0);

        repeat (4) @(posedge clk);
        #1;
        chk("q_mv_a_empty", q_mv_a.size(), 0);
        chk("q_mv_b_empty", q_mv_b.size(), 0);
        chk("q_pix_empty", q_pix.size(), 0);
        chk("c_no_moves", c_moves, 0);
        chk("b_col", int'(b_col), 1);
        chk("b_map", int'(b_map), 0);
        chk("c_map", int'(c_map), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
